pong_draw_controller: RTL and testbench
=======================================

# pong_draw_controller

Frame-rate draw sequencer for the Pong game. It sits between the game-state logic and the single `vga_adapter` instance (160x120, 3-bit colour). Once per frame tick it erases the previous left paddle, right paddle and ball rectangles, then draws them at their new positions. It drives the adapter's `x`/`y`/`colour`/`plot` port at one pixel per clock.

## Interface
Parameters:
- FRAME_TICKS, 833333: clocks per frame (50 MHz / 60 Hz).
- PADDLE_W, 2: paddle width in pixels.
- PADDLE_H, 16: paddle height in pixels.
- BALL_SIZE, 2: ball edge length in pixels.
- LEFT_X, 4: left paddle x origin.
- RIGHT_X, 154: right paddle x origin.
- FG_COLOUR, 3'b111: draw colour.
- BG_COLOUR, 3'b000: erase colour.

Ports:
- CLOCK_50  in  1  system clock. One clock; all logic on its rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- enable  in  1  high allows frame ticks to start frames.
- lpad_y  in  7  left paddle top y.
- rpad_y  in  7  right paddle top y.
- ball_x  in  8  ball left x.
- ball_y  in  7  ball top y.
- frame_start  out  1  one-cycle pulse in the LATCH cycle.
- busy  out  1  high from LATCH through the last pixel cycle.
- x  out  8  pixel x, to adapter.
- y  out  7  pixel y, to adapter.
- colour  out  3  pixel colour, to adapter.
- writeEn  out  1  plot strobe, to adapter.

## Operation
- Tick counter: counts 0..FRAME_TICKS-1 and wraps; the tick is asserted at the terminal count.
  - While enable=0 the counter is held at 0 and `pending` is cleared.
- Pending flag:
  - A tick sets `pending`.
  - Multiple ticks before service collapse into one.
  - Leaving IDLE clears `pending`.
- State machine:
  - IDLE: goes to LATCH when `pending` is set.
  - LATCH: 1 cycle.
    - Copies the current new-position registers into the old-position registers.
    - Samples the inputs into the new-position registers.
    - Clamps lpad_y and rpad_y to at most 120-PADDLE_H. Ball coordinates are not clamped.
    - Pulses frame_start.
  - ERASE: scans old L paddle, then old R paddle, then old ball, all in BG_COLOUR.
  - DRAW: scans new L paddle, then new R paddle, then new ball, all in FG_COLOUR.
  - After the last DRAW pixel, returns to IDLE.
- Rectangle scan:
  - Raster order: dx inner loop 0..W-1, dy outer loop 0..H-1.
  - Exactly one cycle per pixel, with no gap cycles between rectangles or between phases.
- Clipping: a pixel with x>159 or y>119 still consumes its cycle, but writeEn=0 for that cycle. Its x/y still present the unclipped low bits.
- Erase-all-before-draw-all guarantees overlapping objects are never left erased.
- enable falling mid-frame does not abort the frame; the current frame completes.
- Old-position registers reset to 0, so the first frame erases at (LEFT_X,0), (RIGHT_X,0) and (0,0). This is harmless on the black background.
- Arithmetic:
  - Pixel x = origin + dx, computed 9 bits wide.
  - Pixel y = origin + dy, computed 8 bits wide.
  - Clip tests use the full width; outputs are truncated to 8 and 7 bits.

## Timing
- Reset (async): takes effect immediately.
  - x, y, colour, writeEn, busy and frame_start = 0.
  - State IDLE; counter, pending and all position registers = 0.
- The tick at cycle T sets `pending` at T+1. LATCH is at T+2. The first pixel is on x/y/colour/writeEn at T+3.
- All outputs are registered. writeEn is high only in pixel cycles (unless clipped).
- Pixel cycles per frame: P = 2*(2*PADDLE_W*PADDLE_H + BALL_SIZE^2), which is 136 at the defaults. busy is high for P+1 cycles.
- A tick arriving while busy is held. At least one IDLE cycle separates frames.
- A reset asserted mid-frame abandons the scan. After release the controller sits in IDLE until the next tick.

## Test plan
- Reset: assert resetn=0 mid-scan -> all outputs 0 with no clock edge. After release: IDLE, no writes until a tick.
- Nominal frame: FRAME_TICKS=10; lpad_y=10, rpad_y=50, ball=(80,60).
  - Second frame shows exactly 136 writeEn cycles, contiguous after the LATCH cycle.
  - First 68 cycles are BG, last 68 are FG.
  - Draw starts at (4,10), then (5,10), then (4,11).
  - The last pixel is (81,61).
- Clamp: lpad_y=127 -> left paddle drawn over y=104..119 with no clipped cycles.
- Clip: ball=(159,119) -> in the draw phase only (159,119) is written. The 3 clipped cycles have writeEn=0, giving 133 writes out of 136 cycles.
- Overrun: FRAME_TICKS=50, which is less than 137.
  - Ticks during busy collapse to one pending request.
  - Frames run back-to-back with exactly 1 IDLE cycle between them.
  - frame_start count equals the number of frames serviced.
- Enable: drop enable mid-frame -> the frame completes (136 pixel cycles). No further frame_start while enable=0. After re-enable, the first tick occurs FRAME_TICKS cycles later.

Source files
------------

// File: rtl/pong_draw_controller.sv
// Frame-rate draw sequencer for Pong: once per frame tick it erases the old paddles and ball,
// then redraws them at their new positions, one pixel per clock into a 160x120 vga_adapter.
module pong_draw_controller #(
  parameter int         FRAME_TICKS = 833333,
  parameter int         PADDLE_W    = 2,
  parameter int         PADDLE_H    = 16,
  parameter int         BALL_SIZE   = 2,
  parameter int         LEFT_X      = 4,
  parameter int         RIGHT_X     = 154,
  parameter logic [2:0] FG_COLOUR   = 3'b111,
  parameter logic [2:0] BG_COLOUR   = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       enable,
  input  logic [6:0] lpad_y,
  input  logic [6:0] rpad_y,
  input  logic [7:0] ball_x,
  input  logic [6:0] ball_y,
  output logic       frame_start,
  output logic       busy,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       writeEn
);

  localparam int               CNT_W     = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(FRAME_TICKS - 1);
  localparam logic [6:0]       PAD_Y_MAX = 7'(120 - PADDLE_H);
  localparam logic [7:0]       PAD_W     = 8'(PADDLE_W);
  localparam logic [7:0]       PAD_H     = 8'(PADDLE_H);
  localparam logic [7:0]       BALL_E    = 8'(BALL_SIZE);
  localparam logic [7:0]       LX        = 8'(LEFT_X);
  localparam logic [7:0]       RX        = 8'(RIGHT_X);
  localparam logic [8:0]       X_MAX     = 9'd159;
  localparam logic [7:0]       Y_MAX     = 8'd119;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_ERASE,
    S_DRAW
  } state_t;

  state_t state;

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic             pending;

  logic [6:0] old_l, old_r, old_by;
  logic [7:0] old_bx;
  logic [6:0] new_l, new_r, new_by;
  logic [7:0] new_bx;

  // Scan position of the pixel currently presented on the outputs.
  logic       scan_draw;
  logic [1:0] scan_obj;
  logic [7:0] scan_dx, scan_dy;

  logic       nxt_draw;
  logic [1:0] nxt_obj;
  logic [7:0] nxt_dx, nxt_dy;
  logic       last_pixel;
  logic [7:0] obj_w, obj_h;
  logic [7:0] org_x;
  logic [6:0] org_y;
  logic [8:0] pix_x;
  logic [7:0] pix_y;
  logic       pix_clip;

  assign tick = enable && (tick_cnt == TICK_LAST);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      tick_cnt <= '0;
    end else if (!enable || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // A tick wins over the idle-exit clear so a request is never dropped.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      pending <= 1'b0;
    end else if (!enable) begin
      pending <= 1'b0;
    end else if (tick) begin
      pending <= 1'b1;
    end else if (state == S_IDLE) begin
      pending <= 1'b0;
    end
  end

  always_comb begin
    obj_w = PAD_W;
    obj_h = PAD_H;
    if (scan_obj == 2'd2) begin
      obj_w = BALL_E;
      obj_h = BALL_E;
    end
  end

  // Advance the raster: dx inner, dy outer, then next object, then erase -> draw.
  always_comb begin
    nxt_draw   = scan_draw;
    nxt_obj    = scan_obj;
    nxt_dx     = scan_dx;
    nxt_dy     = scan_dy;
    last_pixel = 1'b0;
    if (state == S_LATCH) begin
      nxt_draw = 1'b0;
      nxt_obj  = 2'd0;
      nxt_dx   = 8'd0;
      nxt_dy   = 8'd0;
    end else if (scan_dx != obj_w - 8'd1) begin
      nxt_dx = scan_dx + 8'd1;
    end else begin
      nxt_dx = 8'd0;
      if (scan_dy != obj_h - 8'd1) begin
        nxt_dy = scan_dy + 8'd1;
      end else begin
        nxt_dy = 8'd0;
        if (scan_obj != 2'd2) begin
          nxt_obj = scan_obj + 2'd1;
        end else begin
          nxt_obj = 2'd0;
          if (!scan_draw) begin
            nxt_draw = 1'b1;
          end else begin
            last_pixel = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    org_x = LX;
    org_y = nxt_draw ? new_l : old_l;
    case (nxt_obj)
      2'd1: begin
        org_x = RX;
        org_y = nxt_draw ? new_r : old_r;
      end
      2'd2: begin
        org_x = nxt_draw ? new_bx : old_bx;
        org_y = nxt_draw ? new_by : old_by;
      end
      default: ;
    endcase
    pix_x    = {1'b0, org_x} + {1'b0, nxt_dx};
    pix_y    = {1'b0, org_y} + nxt_dy;
    pix_clip = (pix_x > X_MAX) || (pix_y > Y_MAX);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      x           <= '0;
      y           <= '0;
      colour      <= '0;
      writeEn     <= 1'b0;
      scan_draw   <= 1'b0;
      scan_obj    <= '0;
      scan_dx     <= '0;
      scan_dy     <= '0;
      old_l       <= '0;
      old_r       <= '0;
      old_bx      <= '0;
      old_by      <= '0;
      new_l       <= '0;
      new_r       <= '0;
      new_bx      <= '0;
      new_by      <= '0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pending) begin
            state       <= S_LATCH;
            frame_start <= 1'b1;
            busy        <= 1'b1;
            old_l       <= new_l;
            old_r       <= new_r;
            old_bx      <= new_bx;
            old_by      <= new_by;
            new_l       <= (lpad_y > PAD_Y_MAX) ? PAD_Y_MAX : lpad_y;
            new_r       <= (rpad_y > PAD_Y_MAX) ? PAD_Y_MAX : rpad_y;
            new_bx      <= ball_x;
            new_by      <= ball_y;
          end
        end
        default: begin
          if (last_pixel) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            x       <= '0;
            y       <= '0;
            colour  <= '0;
            writeEn <= 1'b0;
          end else begin
            state     <= nxt_draw ? S_DRAW : S_ERASE;
            scan_draw <= nxt_draw;
            scan_obj  <= nxt_obj;
            scan_dx   <= nxt_dx;
            scan_dy   <= nxt_dy;
            x         <= pix_x[7:0];
            y         <= pix_y[6:0];
            colour    <= nxt_draw ? FG_COLOUR : BG_COLOUR;
            writeEn   <= !pix_clip;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_draw_controller.sv
// Scoreboard bench for pong_draw_controller: each frame_start pushes the expected pixel stream,
// every busy pixel cycle pops and compares {writeEn, x, y, colour}.
`timescale 1ns/1ps
module tb_pong_draw_controller;

  localparam int FT = 10;

  logic       clk = 1'b0;
  logic       resetn, enable;
  logic [6:0] lpad_y, rpad_y, ball_y;
  logic [7:0] ball_x;
  logic       frame_start, busy, writeEn;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;

  pong_draw_controller #(.FRAME_TICKS(FT)) dut (
    .CLOCK_50(clk), .resetn(resetn), .enable(enable),
    .lpad_y(lpad_y), .rpad_y(rpad_y), .ball_x(ball_x), .ball_y(ball_y),
    .frame_start(frame_start), .busy(busy),
    .x(x), .y(y), .colour(colour), .writeEn(writeEn)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference model state
  logic [18:0] exp_q[$];
  logic [18:0] exp_e;
  int m_old_l, m_old_r, m_old_bx, m_old_by;
  int m_new_l, m_new_r, m_new_bx, m_new_by;
  int rec_l, rec_r, rec_bx, rec_by;

  int frames_started = 0, frames_done = 0;
  int cur_px, cur_we, last_px, last_we;
  int idle_run = 0, last_gap = 0;
  logic prev_busy = 1'b0;
  logic seen_fg;
  logic [14:0] first_fg, last_xy;

  task automatic pushRect(input int ox, input int oy, input int w, input int h, input logic [2:0] col);
    for (int dy = 0; dy < h; dy++) begin
      for (int dx = 0; dx < w; dx++) begin
        int px, py;
        logic we;
        logic [7:0] xs;
        logic [6:0] ys;
        px = ox + dx;
        py = oy + dy;
        we = (px <= 159) && (py <= 119);
        xs = 8'(px);
        ys = 7'(py);
        exp_q.push_back({we, xs, ys, col});
      end
    end
  endtask

  task automatic pushFrame();
    m_old_l  = m_new_l;
    m_old_r  = m_new_r;
    m_old_bx = m_new_bx;
    m_old_by = m_new_by;
    m_new_l  = (rec_l > 104) ? 104 : rec_l;
    m_new_r  = (rec_r > 104) ? 104 : rec_r;
    m_new_bx = rec_bx;
    m_new_by = rec_by;
    pushRect(4,   m_old_l, 2, 16, 3'b000);
    pushRect(154, m_old_r, 2, 16, 3'b000);
    pushRect(m_old_bx, m_old_by, 2, 2, 3'b000);
    pushRect(4,   m_new_l, 2, 16, 3'b111);
    pushRect(154, m_new_r, 2, 16, 3'b111);
    pushRect(m_new_bx, m_new_by, 2, 2, 3'b111);
  endtask

  // Monitor: sample between edges, pop one expectation per busy pixel cycle.
  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      m_old_l = 0; m_old_r = 0; m_old_bx = 0; m_old_by = 0;
      m_new_l = 0; m_new_r = 0; m_new_bx = 0; m_new_by = 0;
      prev_busy = 1'b0;
      idle_run  = 0;
      cur_px    = 0;
      cur_we    = 0;
    end else begin
      if (frame_start) begin
        frames_started++;
        last_gap = idle_run;
        idle_run = 0;
        checkOutput("start_busy", 32'(busy), 1);
        checkOutput("queue_empty_at_start", exp_q.size(), 0);
        pushFrame();
        cur_px  = 0;
        cur_we  = 0;
        seen_fg = 1'b0;
      end else if (busy) begin
        cur_px++;
        if (writeEn) cur_we++;
        if (exp_q.size() == 0) begin
          checkOutput("extra_pixel", 1, 0);
        end else begin
          exp_e = exp_q.pop_front();
          checkOutput("pixel", {13'd0, writeEn, x, y, colour}, {13'd0, exp_e});
        end
        if (colour == 3'b111 && !seen_fg) begin
          seen_fg  = 1'b1;
          first_fg = {x, y};
        end
        last_xy = {x, y};
      end else begin
        idle_run++;
        checkOutput("idle_writeEn", 32'(writeEn), 0);
        if (prev_busy) begin
          frames_done++;
          last_px = cur_px;
          last_we = cur_we;
          checkOutput("queue_empty_at_end", exp_q.size(), 0);
        end
      end
      prev_busy = busy;
    end
    rec_l  = lpad_y;
    rec_r  = rpad_y;
    rec_bx = ball_x;
    rec_by = ball_y;
  end

  task automatic applyStimulus(input logic en, input int l, input int r, input int bx, input int by);
    @(posedge clk);
    #1;
    enable = en;
    lpad_y = 7'(l);
    rpad_y = 7'(r);
    ball_x = 8'(bx);
    ball_y = 7'(by);
  endtask

  task automatic waitFrameStart();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (frame_start) return;
    end
    checkOutput("frame_start_timeout", 0, 1);
  endtask

  task automatic waitFrameEnd();
    int target;
    target = frames_done + 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (frames_done >= target) return;
    end
    checkOutput("frame_end_timeout", 0, 1);
  endtask

  task automatic checkOutputsZero(input string tag);
    checkOutput({tag, "_x"}, 32'(x), 0);
    checkOutput({tag, "_y"}, 32'(y), 0);
    checkOutput({tag, "_colour"}, 32'(colour), 0);
    checkOutput({tag, "_writeEn"}, 32'(writeEn), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_frame_start"}, 32'(frame_start), 0);
  endtask

  initial begin
    int snap, n;
    resetn = 1'b0;
    enable = 1'b0;
    lpad_y = '0;
    rpad_y = '0;
    ball_x = '0;
    ball_y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutputsZero("reset");
    resetn = 1'b1;

    // Nominal: the second frame erases and redraws the same positions.
    applyStimulus(1'b1, 10, 50, 80, 60);
    waitFrameEnd();
    waitFrameEnd();
    checkOutput("nominal_pixels", last_px, 136);
    checkOutput("nominal_writes", last_we, 136);
    checkOutput("nominal_gap", last_gap, 1);
    checkOutput("nominal_first_draw", 32'(first_fg), 32'({8'd4, 7'd10}));
    checkOutput("nominal_last_pixel", 32'(last_xy), 32'({8'd81, 7'd61}));

    // Clamp: paddle at 127 must land at 104..119.
    waitFrameStart();
    applyStimulus(1'b1, 127, 50, 80, 60);
    waitFrameEnd();
    waitFrameEnd();
    checkOutput("clamp_pixels", last_px, 136);
    checkOutput("clamp_writes", last_we, 136);
    checkOutput("clamp_first_draw", 32'(first_fg), 32'({8'd4, 7'd104}));

    // Clip: ball in the bottom-right corner.
    waitFrameStart();
    applyStimulus(1'b1, 127, 50, 159, 119);
    waitFrameEnd();
    waitFrameEnd();
    checkOutput("clip_pixels", last_px, 136);
    checkOutput("clip_writes", last_we, 133);
    checkOutput("clip_last_pixel", 32'(last_xy), 32'({8'd160, 7'd120}));
    waitFrameEnd();
    checkOutput("clip_erase_writes", last_we, 130);
    checkOutput("overrun_gap", last_gap, 1);

    // Enable drop mid-frame: the frame completes, then nothing starts.
    waitFrameStart();
    @(posedge clk);
    #1;
    enable = 1'b0;
    waitFrameEnd();
    checkOutput("disable_pixels", last_px, 136);
    checkOutput("start_count", frames_started, frames_done);
    snap = frames_started;
    repeat (40) @(negedge clk);
    #1;
    checkOutput("no_start_disabled", frames_started, snap);
    checkOutput("idle_disabled", 32'(busy), 0);
    @(posedge clk);
    #1;
    enable = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (frame_start) break;
    end
    checkOutput("reenable_latency", n, FT + 1);

    // Mid-scan reset: outputs clear without an edge, then a fresh frame from zeroed positions.
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checkOutputsZero("midreset");
    #4;
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("post_reset_busy", 32'(busy), 0);
    end
    waitFrameEnd();
    checkOutput("post_reset_pixels", last_px, 136);
    checkOutput("post_reset_writes", last_we, 133);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
